// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the debug unit dump controllers.
//   dump_state_e       : state encoding of the register-bank dump sequencer
//   DBG_CMD_DUMP_REGS  : command-decoder opcode that produces the dump i_start
// -----------------------------------------------------------------------------
package debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT_WAIT,
        ST_ADDR,
        ST_CAPTURE,
        ST_SEND,
        ST_NEXT,
        ST_CKSUM,
        ST_DONE
    } dump_state_e;

    // ASCII 'R' received by the debug UART command decoder.
    localparam logic [7:0] DBG_CMD_DUMP_REGS = 8'h52;

endpackage

// File: rtl/byte_serializer.sv
// -----------------------------------------------------------------------------
// byte_serializer
// Splits a loaded word into bytes, LSB byte first, over a valid/ready port.
// Ports:
//   i_clk, i_reset  : clock, asynchronous active-high reset
//   i_load          : one-cycle load of i_word (starts a new word)
//   i_word          : word to serialize
//   i_single        : send only the lowest byte of i_word
//   o_tx_data       : current byte (registered)
//   o_tx_valid      : byte valid (registered), held until accepted
//   i_tx_ready      : sink accepts byte
//   o_done          : high in the cycle the final byte is accepted
// -----------------------------------------------------------------------------
module byte_serializer #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_word,
    input  logic               i_single,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_done
);

    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    logic [NB_DATA-1:0] shift_q;
    logic [NB_CNT-1:0]  cnt_q;
    logic [NB_CNT-1:0]  last_q;
    logic               valid_q;
    logic               xfer;

    assign xfer       = valid_q && i_tx_ready;
    assign o_done     = xfer && (cnt_q == last_q);
    assign o_tx_data  = shift_q[NB_BYTE-1:0];
    assign o_tx_valid = valid_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
        end else if (i_load) begin
            shift_q <= i_word;
            cnt_q   <= '0;
            last_q  <= i_single ? '0 : NB_CNT'(N_BYTES - 1);
            valid_q <= 1'b1;
        end else if (xfer) begin
            shift_q <= shift_q >> NB_BYTE;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == last_q) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_dump_ctrl
// Dumps the register bank through the decode stage's debug read port:
// requests a halt, waits for acknowledge, then reads addresses 0..N_REGS-1
// and streams every word as bytes (LSB first) toward the UART TX FIFO.
// Build option: define REGDUMP_CHECKSUM_EN to append one XOR checksum byte
// covering every byte sent in the dump.
// Ports:
//   i_clk, i_reset  : clock, asynchronous active-high reset
//   i_start         : one-cycle dump command (ignored unless idle)
//   i_halted        : pipeline halt acknowledge
//   o_halt_req      : halt request, held for the whole dump
//   o_r_addr        : debug read address (address counter)
//   i_r_data        : debug read data
//   o_tx_data/o_tx_valid/i_tx_ready : byte stream to TX FIFO
//   o_busy          : dump in progress
//   o_done          : one-cycle completion pulse
// -----------------------------------------------------------------------------
module regfile_dump_ctrl #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int N_REGS  = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_halted,
    output logic               o_halt_req,
    output logic [NB_ADDR-1:0] o_r_addr,
    input  logic [NB_DATA-1:0] i_r_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    import debug_pkg::*;

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_REGS - 1);

    dump_state_e        state_q, state_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic               halt_q, busy_q, done_q;

    logic               ser_load;
    logic [NB_DATA-1:0] ser_word;
    logic               ser_single;
    logic               ser_done;

`ifdef REGDUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] cksum_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cksum_q <= '0;
        end else if (state_q == ST_IDLE && i_start) begin
            cksum_q <= '0;
        end else if (o_tx_valid && i_tx_ready) begin
            cksum_q <= cksum_q ^ o_tx_data;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ser_load   = 1'b0;
        ser_word   = i_r_data;
        ser_single = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_HALT_WAIT;
                    addr_d  = '0;
                end
            end
            ST_HALT_WAIT: begin
                if (i_halted) begin
                    state_d = ST_ADDR;
                end
            end
            // Settle cycle for the decode stage's combinational read mux.
            ST_ADDR: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                ser_load = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (ser_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (addr_q == LAST_ADDR) begin
`ifdef REGDUMP_CHECKSUM_EN
                    // Last word's final byte was folded in on the previous edge.
                    state_d    = ST_CKSUM;
                    ser_load   = 1'b1;
                    ser_word   = NB_DATA'(cksum_q);
                    ser_single = 1'b1;
`else
                    state_d    = ST_DONE;
`endif
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_ADDR;
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            ST_CKSUM: begin
                if (ser_done) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            halt_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            halt_q  <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            busy_q  <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    byte_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_ser (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (ser_load),
        .i_word     (ser_word),
        .i_single   (ser_single),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_done     (ser_done)
    );

    assign o_halt_req = halt_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_r_addr   = addr_q;

endmodule
